ccff_bitstream_loader: RTL and testbench

- Drives the configuration-chain input (ccff_head) of a tile string from a word-wide host stream, one bit per enabled prog_clk edge.
- Gates chain shifting via shift_en, which goes to an external clock-gate cell.
- Optional verify pass: re-streams the same bitstream and compares ccff_tail of the last tile against the bits re-entering ccff_head.
- Sits at the fabric top level, between the bitstream DMA/host port and the first tile's ccff_head; the last tile's ccff_tail feeds back to it.

---
 rtl/ccff_loader_pkg.sv | 20 ++
 rtl/ccff_word_serializer.sv | 59 +++++
 rtl/ccff_bitstream_loader.sv | 123 ++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic int words_per_pass(input int chain_len, input int data_w);
        return (chain_len + data_w - 1) / data_w;
    endfunction

    // Usable bits in the final word of a pass; a zero remainder means a full word.
    function automatic int last_word_bits(input int chain_len, input int data_w);
        return ((chain_len % data_w) == 0) ? data_w : (chain_len % data_w);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Single-word buffer that turns host words into one chain bit per enabled edge, LSB first.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              last_bit,
    input  logic              final_pass,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              shift_en,
    output logic              ccff_head
);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] buf_q, buf_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              vld_q, vld_d;
    logic              word_end;

    always_comb begin
        buf_d     = buf_q;
        idx_d     = idx_q;
        vld_d     = vld_q;
        shift_en  = active && vld_q;
        // The pass boundary also ends a word, which discards the unused top bits of a partial word.
        word_end  = shift_en && (last_bit || (idx_q == IW'(DATA_W - 1)));
        // Refill in the same edge as the last bit goes out, unless the run ends there.
        s_ready   = active && (!vld_q || (word_end && !(last_bit && final_pass)));
        ccff_head = shift_en && buf_q[idx_q];

        if (s_valid && s_ready) begin
            buf_d = s_data;
            vld_d = 1'b1;
            idx_d = '0;
        end else if (word_end || !active) begin
            vld_d = 1'b0;
            idx_d = '0;
        end else if (shift_en) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
        buf_q <= buf_d;
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Loads a tile configuration chain from a host word stream and optionally verifies it
// by re-streaming the bitstream while comparing the chain tail against the head.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              verify_en,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_cnt
);
    localparam int WORDS    = words_per_pass(CHAIN_LEN, DATA_W);
    localparam int PASS_END = (WORDS - 1) * DATA_W + last_word_bits(CHAIN_LEN, DATA_W) - 1;
    localparam int PCW      = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    state_e           state_q, state_d;
    logic             ver_q, ver_d;
    logic [PCW-1:0]   pcnt_q, pcnt_d;
    logic [CNT_W-1:0] mm_q, mm_d;
    logic             pass_q, pass_d;
    logic             active, pass_last, final_pass;

    always_comb begin
        state_d    = state_q;
        ver_d      = ver_q;
        pcnt_d     = pcnt_q;
        mm_d       = mm_q;
        pass_d     = pass_q;
        active     = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
        pass_last  = (pcnt_q == PCW'(PASS_END));
        final_pass = (state_q == ST_VERIFY) || !ver_q;

        if (shift_en) begin
            pcnt_d = pass_last ? '0 : pcnt_q + 1'b1;
        end
        if ((state_q == ST_VERIFY) && shift_en && (ccff_tail != ccff_head)) begin
            mm_d = sat_inc(mm_q);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    ver_d   = verify_en;
                    mm_d    = '0;
                    pass_d  = 1'b0;
                    pcnt_d  = '0;
                end
            end
            ST_LOAD: begin
                if (shift_en && pass_last) begin
                    if (ver_q) begin
                        state_d = ST_VERIFY;
                    end else begin
                        state_d = ST_DONE;
                        pass_d  = 1'b1;
                    end
                end
            end
            ST_VERIFY: begin
                if (shift_en && pass_last) begin
                    state_d = ST_DONE;
                    pass_d  = (mm_d == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ccff_word_serializer #(
        .DATA_W(DATA_W)
    ) u_ser (
        .clk       (prog_clk),
        .rst       (prog_reset),
        .active    (active),
        .last_bit  (pass_last),
        .final_pass(final_pass),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .shift_en  (shift_en),
        .ccff_head (ccff_head)
    );

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q <= ST_IDLE;
            ver_q   <= 1'b0;
            pcnt_q  <= '0;
            mm_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ver_q   <= ver_d;
            pcnt_q  <= pcnt_d;
            mm_q    <= mm_d;
            pass_q  <= pass_d;
        end
    end

    assign busy         = active;
    assign done         = (state_q == ST_DONE);
    assign pass         = pass_q;
    assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: behavioural chain model on each DUT, table of runs plus reset sequences.
module tb_ccff_bitstream_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       verify_en;
    logic       s_valid;
    logic [3:0] s_data;

    logic        s_ready, head, tail, shift_en, busy, done, pass;
    logic [15:0] mm;
    logic        s_ready2, head2, tail2, shift_en2, busy2, done2, pass2;
    logic [1:0]  mm2;

    logic [9:0] chain1 = '0;
    logic [9:0] chain2 = '0;
    int nshift = 0;
    int nbub   = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ccff_bitstream_loader #(.CHAIN_LEN(10), .DATA_W(4), .CNT_W(16)) dut (
        .prog_clk(clk), .prog_reset(rst), .start(start), .verify_en(verify_en),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .ccff_head(head),
        .ccff_tail(tail), .shift_en(shift_en), .busy(busy), .done(done),
        .pass(pass), .mismatch_cnt(mm)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(10), .DATA_W(4), .CNT_W(2)) dut2 (
        .prog_clk(clk), .prog_reset(rst), .start(start), .verify_en(verify_en),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready2), .ccff_head(head2),
        .ccff_tail(tail2), .shift_en(shift_en2), .busy(busy2), .done(done2),
        .pass(pass2), .mismatch_cnt(mm2)
    );

    // Chain models: bit 0 of the stream ends up at the tail end after a full pass.
    always @(posedge clk) begin
        if (shift_en)  chain1 <= {chain1[8:0], head};
        if (shift_en2) chain2 <= {chain2[8:0], head2};
        if (shift_en)  nshift <= nshift + 1;
        if (busy && !shift_en) nbub <= nbub + 1;
    end
    assign tail  = chain1[9];
    assign tail2 = chain2[9];

    typedef struct {
        logic       ven;
        logic [11:0] p1;
        logic [11:0] p2;
        int         gap;
        logic       pulse;
        int         shifts;
        int         mm;
        int         mm2;
        logic       pas;
        logic [9:0] chain;
        int         bub;
    } rec_t;

    rec_t vec[9];

    function automatic rec_t mk(input logic ven, input logic [11:0] p1, input logic [11:0] p2,
                                input int gap, input logic pulse, input int shifts, input int m,
                                input int m2, input logic pas, input logic [9:0] chain, input int bub);
        rec_t r;
        r.ven = ven; r.p1 = p1; r.p2 = p2; r.gap = gap; r.pulse = pulse;
        r.shifts = shifts; r.mm = m; r.mm2 = m2; r.pas = pas; r.chain = chain; r.bub = bub;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " s_ready"}, {31'd0, s_ready}, 0);
        chk({tag, " ccff_head"}, {31'd0, head}, 0);
        chk({tag, " shift_en"}, {31'd0, shift_en}, 0);
        chk({tag, " busy"}, {31'd0, busy}, 0);
        chk({tag, " done"}, {31'd0, done}, 0);
        chk({tag, " pass"}, {31'd0, pass}, 0);
        chk({tag, " mismatch_cnt"}, {16'd0, mm}, 0);
        chk({tag, " dut2 idle"}, {28'd0, s_ready2, busy2, done2, pass2}, 0);
        chk({tag, " dut2 mismatch_cnt"}, {30'd0, mm2}, 0);
    endtask

    task automatic send_word(input logic [3:0] d);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            start = 1'b0;
            t++;
        end
        chk("handshake ready", {31'd0, s_ready}, 1);
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic run_rec(input int k);
        rec_t r;
        int s0, b0, t;
        logic [11:0] w;
        string tag;
        r   = vec[k];
        tag = $sformatf("run%0d", k);
        s0  = nshift;
        b0  = nbub;
        verify_en = r.ven;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int p = 0; p < (r.ven ? 2 : 1); p++) begin
            w = (p == 0) ? r.p1 : r.p2;
            for (int i = 0; i < 3; i++) begin
                if (r.pulse && i == 1 && p == int'(r.ven)) start = 1'b1;
                send_word(w[4*i +: 4]);
                if (i < 2) repeat (r.gap) @(negedge clk);
            end
        end
        t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " done"}, {31'd0, done}, 1);
        chk({tag, " busy"}, {31'd0, busy}, 0);
        chk({tag, " shifts"}, nshift - s0, r.shifts);
        chk({tag, " bubbles"}, nbub - b0, r.bub);
        chk({tag, " pass"}, {31'd0, pass}, {31'd0, r.pas});
        chk({tag, " mismatch_cnt"}, {16'd0, mm}, r.mm);
        chk({tag, " chain"}, {22'd0, chain1}, {22'd0, r.chain});
        chk({tag, " dut2 mismatch_cnt"}, {30'd0, mm2}, r.mm2);
        chk({tag, " dut2 pass"}, {31'd0, pass2}, {31'd0, r.pas});
        chk({tag, " dut2 chain"}, {22'd0, chain2}, {22'd0, r.chain});
    endtask

    initial begin
        int s0, t;
        logic rdy;
        rst = 1'b1; start = 1'b0; verify_en = 1'b0; s_valid = 1'b0; s_data = '0;

        //           ven pass1    pass2    gap pulse shifts mm mm2 pass chain    bubbles
        vec[0] = mk(0, 12'h35A, 12'h35A, 0, 0, 10, 0, 0, 1, 10'h16B, 1);
        vec[1] = mk(1, 12'h35A, 12'h35A, 0, 0, 20, 0, 0, 1, 10'h16B, 1);
        vec[2] = mk(1, 12'h35A, 12'h34A, 0, 0, 20, 1, 1, 0, 10'h14B, 1);
        vec[3] = mk(1, 12'h35A, 12'h36A, 0, 0, 20, 2, 2, 0, 10'h15B, 1);
        vec[4] = mk(1, 12'h35A, 12'hF5A, 0, 0, 20, 0, 0, 1, 10'h16B, 1);
        vec[5] = mk(0, 12'h35A, 12'h35A, 6, 0, 10, 0, 0, 1, 10'h16B, 7);
        vec[6] = mk(0, 12'h35A, 12'h35A, 0, 1, 10, 0, 0, 1, 10'h16B, 1);
        vec[7] = mk(1, 12'h35A, 12'h35A, 0, 1, 20, 0, 0, 1, 10'h16B, 1);
        vec[8] = mk(1, 12'h35A, 12'h345, 0, 0, 20, 5, 3, 0, 10'h28B, 1);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("reset");

        for (int k = 0; k < 9; k++) run_rec(k);

        // Abort a load after five shifts, then load again from scratch.
        s0 = nshift;
        verify_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_data  = 4'hA;
        s_valid = 1'b1;
        t = 0;
        while ((nshift - s0) < 5 && t < 50) begin
            rdy = s_ready;
            @(negedge clk);
            t++;
            if (rdy) s_data = 4'h5;
        end
        chk("midreset shifts before reset", nshift - s0, 5);
        chk("midreset shifting before reset", {31'd0, shift_en}, 1);
        rst = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk_idle("midreset");
        rst = 1'b0;
        @(negedge clk);
        run_rec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
